cfu_cmd_issuer: RTL and testbench
=================================

CFU_CMD_ISSUER -- requirements
Module: cfu_cmd_issuer

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning request FIFO entries (power of two, 2..16).
REQ-002 SHALL have parameter TIMEOUT, default 4096, meaning the maximum number of WAIT_RSP cycles before a command is abandoned.
REQ-003 SHALL have port clk  in  1  clock; all logic on the rising edge.
REQ-004 SHALL have port reset  in  1  reset; reset is synchronous and active-high.
REQ-005 SHALL have ports req_valid in 1 / req_ready out 1: upstream request handshake.
REQ-006 SHALL have ports req_function_id in 10 / req_inputs_0 in 32 / req_inputs_1 in 32: request fields, captured into the FIFO.
REQ-007 SHALL have ports cmd_valid out 1 / cmd_ready in 1: command handshake toward the CFU.
REQ-008 SHALL have ports cmd_payload_function_id out 10 / cmd_payload_inputs_0 out 32 / cmd_payload_inputs_1 out 32: command payload.
REQ-009 SHALL have ports rsp_valid in 1 / rsp_ready out 1 / rsp_payload_outputs_0 in 32: CFU response handshake.
REQ-010 SHALL have ports res_valid out 1 / res_ready in 1 / res_data out 32 / res_timeout out 1: result toward upstream.
REQ-011 SHALL have ports busy out 1 (FIFO non-empty or FSM not IDLE) and err_sticky out 1 (any timeout since reset).

Function
REQ-012 SHALL hold requests in a FIFO; req_ready = !full; a push occurs on req_valid & req_ready; there is no bypass, so a push into a full FIFO is refused even if a pop occurs in the same cycle.
REQ-013 SHALL use FSM states IDLE, ISSUE, WAIT_RSP and DELIVER.
REQ-014 SHALL move IDLE->ISSUE on the cycle after the FIFO becomes non-empty.
REQ-015 SHALL in ISSUE drive cmd_valid=1 and present the FIFO head on the cmd_payload_* outputs.
REQ-016 SHALL keep the payload stable until cmd_valid & cmd_ready, then pop the FIFO and go to WAIT_RSP.
REQ-017 SHALL never deassert cmd_valid in ISSUE before the handshake completes.
REQ-018 SHALL allow at most one outstanding command; cmd_valid=0 in every state other than ISSUE.
REQ-019 SHALL in WAIT_RSP drive rsp_ready=1 (0 in all other states), count cycles from 0, and on rsp_valid register rsp_payload_outputs_0 into res_data, clear res_timeout, and go to DELIVER.
REQ-020 SHALL, if the WAIT_RSP counter reaches TIMEOUT-1 without rsp_valid, set res_data=0, res_timeout=1 and err_sticky=1, and go to DELIVER.
REQ-021 SHALL treat rsp_valid and timeout in the same cycle as a normal response.
REQ-022 SHALL in DELIVER hold res_valid=1 with stable res_data and res_timeout until res_ready, then go to ISSUE if the FIFO is non-empty, else IDLE.
REQ-023 SHALL ignore rsp_valid outside WAIT_RSP, with no state change.
REQ-024 SHALL have a best-case latency of 1 cycle from push to cmd_valid when idle.
REQ-025 SHALL wrap the FIFO pointers modulo FIFO_DEPTH; occupancy count width is log2(FIFO_DEPTH)+1.

Reset
REQ-026 SHALL, while reset=1 for one or more cycles, drive: state IDLE, FIFO empty, counter 0, cmd_valid=0, rsp_ready=0, res_valid=0, res_timeout=0, res_data=0, err_sticky=0, busy=0, req_ready=0.
REQ-027 SHALL assert req_ready=1 on the first cycle after reset deasserts.
REQ-028 SHALL, on reset mid-transaction, discard queued requests and any in-flight response, and produce no res_valid afterward for them.

Verification
REQ-029 SHALL be verified for a single request, fid=0x008, in0=0x40000000, in1=0x40000000, with the CFU answering 2 cycles later with 0x20000000: one cmd handshake, then res_valid=1, res_data=0x20000000, res_timeout=0.
REQ-030 SHALL be verified with 5 back-to-back pushes while cmd_ready=0: req_ready drops after the 4th push, and the 5th is held until the first cmd handshake; the 5 results are delivered in push order.
REQ-031 SHALL be verified with TIMEOUT=16 and no CFU response: res_valid rises 16 cycles after the cmd handshake with res_timeout=1, res_data=0 and err_sticky=1; a following request completes normally while err_sticky stays 1.
REQ-032 SHALL be verified with res_ready held 0 for 10 cycles in DELIVER: res_data is stable, cmd_valid=0, rsp_ready=0, and the next command issues the cycle after res_ready=1.
REQ-033 SHALL be verified with reset asserted during WAIT_RSP with 3 queued entries: all outputs return to their reset values, and no result appears after reset.
REQ-034 SHALL be verified with cmd_ready toggled randomly during ISSUE: the payload never changes while cmd_valid=1 and no handshake has occurred.

Source files
------------

// File: rtl/cfu_cmd_issuer.sv
// cfu_cmd_issuer: queues CFU requests and issues them one at a time, returning each result or a timeout
module cfu_cmd_issuer #(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [9:0]  req_function_id,
  input  logic [31:0] req_inputs_0,
  input  logic [31:0] req_inputs_1,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [9:0]  cmd_payload_function_id,
  output logic [31:0] cmd_payload_inputs_0,
  output logic [31:0] cmd_payload_inputs_1,
  input  logic        rsp_valid,
  output logic        rsp_ready,
  input  logic [31:0] rsp_payload_outputs_0,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_data,
  output logic        res_timeout,
  output logic        busy,
  output logic        err_sticky
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP, DELIVER} state_t;
  state_t state;
  logic [73:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count;
  logic [CW-1:0] cnt;
  logic push, pop, full, queued;
  assign full = count == (AW+1)'(FIFO_DEPTH);
  assign queued = count != '0;
  assign req_ready = !reset && !full;
  assign push = req_valid && req_ready;
  assign pop = cmd_valid && cmd_ready;
  assign {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1} = mem[rd_ptr];
  assign busy = queued || state != IDLE;
  // request storage; entries are only read once count says they are valid
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= {req_function_id, req_inputs_0, req_inputs_1};
  // FIFO pointers wrap naturally because the depth is a power of two
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  // command sequencer with registered handshake outputs and response timeout
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cmd_valid <= 1'b0;
      rsp_ready <= 1'b0;
      res_valid <= 1'b0;
      res_data <= '0;
      res_timeout <= 1'b0;
      err_sticky <= 1'b0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: if (queued) begin
          state <= ISSUE;
          cmd_valid <= 1'b1;
        end
        ISSUE: if (cmd_ready) begin
          state <= WAIT_RSP;
          cmd_valid <= 1'b0;
          rsp_ready <= 1'b1;
          cnt <= '0;
        end
        WAIT_RSP: if (rsp_valid || cnt == CW'(TIMEOUT - 1)) begin
          state <= DELIVER;
          rsp_ready <= 1'b0;
          res_valid <= 1'b1;
          res_data <= rsp_valid ? rsp_payload_outputs_0 : '0;
          res_timeout <= !rsp_valid;
          err_sticky <= err_sticky || !rsp_valid;
        end else cnt <= cnt + 1'b1;
        DELIVER: if (res_ready) begin
          state <= queued ? ISSUE : IDLE;
          cmd_valid <= queued;
          res_valid <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cfu_cmd_issuer.sv
// tb_cfu_cmd_issuer: randomized bench with a transaction-level timing model of the command issuer
module tb_cfu_cmd_issuer;
  localparam int DEPTH = 4;
  localparam int TO = 16;
  localparam int NEVER = 1000;
  logic clk = 0, reset = 1, req_valid = 0, cmd_ready = 0, rsp_valid = 0, res_ready = 0;
  logic [9:0] req_function_id = 0;
  logic [31:0] req_inputs_0 = 0, req_inputs_1 = 0, rsp_payload_outputs_0 = 0;
  logic req_ready, cmd_valid, rsp_ready, res_valid, res_timeout, busy, err_sticky;
  logic [9:0] cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0, cmd_payload_inputs_1, res_data;
  cfu_cmd_issuer #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_function_id(req_function_id), .req_inputs_0(req_inputs_0), .req_inputs_1(req_inputs_1),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_payload_function_id(cmd_payload_function_id),
    .cmd_payload_inputs_0(cmd_payload_inputs_0), .cmd_payload_inputs_1(cmd_payload_inputs_1),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_payload_outputs_0(rsp_payload_outputs_0),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_timeout(res_timeout),
    .busy(busy), .err_sticky(err_sticky));
  always #5 clk = ~clk;
  int passed = 0, total = 0, n = 0;
  logic [73:0] q[$];
  bit txn = 0, to = 0, err_base = 0;
  int h = 0, d = 0, r = 0, prev_q = 0;
  logic [31:0] rsp_v = 0;
  int p_req = 0, p_cmd = 0, p_res = 0, push_limit = 0, pushes = 0, hs_count = 0, hs_edge = 0, next_d = -1;
  bit rst_knob = 1, fix = 0;
  logic [31:0] next_v = 0, hold_v;
  logic [73:0] fix_req = 0;
  int base, hb, seen;
  task automatic chk(string nm, logic [73:0] got, logic [73:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h (sample %0d)", nm, got, exp, n);
  endtask
  // expected outputs derive from queue occupancy and the handshake/response edge numbers of the live transaction
  task automatic check_cycle();
    bit exp_cv = !txn && prev_q > 0;
    bit exp_res = txn && n >= r;
    chk("req_ready", req_ready, !reset && q.size() < DEPTH);
    chk("cmd_valid", cmd_valid, exp_cv);
    if (exp_cv) chk("payload", {cmd_payload_function_id, cmd_payload_inputs_0, cmd_payload_inputs_1}, q[0]);
    chk("rsp_ready", rsp_ready, txn && n >= h && n < r);
    chk("res_valid", res_valid, exp_res);
    if (exp_res) begin
      chk("res_data", res_data, to ? 32'h0 : rsp_v);
      chk("res_timeout", res_timeout, to);
    end
    chk("busy", busy, q.size() > 0 || txn);
    chk("err_sticky", err_sticky, err_base || (exp_res && to));
  endtask
  task automatic drive();
    reset = rst_knob;
    req_valid = pushes < push_limit && $urandom_range(99) < p_req;
    req_function_id = fix ? fix_req[73:64] : 10'($urandom);
    req_inputs_0 = fix ? fix_req[63:32] : $urandom;
    req_inputs_1 = fix ? fix_req[31:0] : $urandom;
    cmd_ready = $urandom_range(99) < p_cmd;
    res_ready = $urandom_range(99) < p_res;
    if (txn && n >= h && n < r) begin
      rsp_valid = n == h + d;
      rsp_payload_outputs_0 = n == h + d ? rsp_v : $urandom;
    end else begin
      rsp_valid = 1'($urandom);
      rsp_payload_outputs_0 = $urandom;
    end
  endtask
  // predicts what the coming rising edge does to the model
  task automatic update();
    int sz = q.size();
    bit cv = !txn && prev_q > 0;
    int k;
    if (reset) begin
      q.delete();
      txn = 0;
      err_base = 0;
      prev_q = 0;
      return;
    end
    if (txn && n >= r && res_ready) begin
      txn = 0;
      if (to) err_base = 1;
    end else if (cv && cmd_ready) begin
      txn = 1;
      h = n + 1;
      hs_edge = h;
      hs_count++;
      if (next_d >= 0) begin
        d = next_d;
        rsp_v = next_v;
        next_d = -1;
      end else begin
        k = $urandom_range(9);
        d = k == 0 ? NEVER : k == 1 ? TO - 1 : int'($urandom_range(5));
        rsp_v = $urandom;
      end
      to = d > TO - 1;
      r = h + 1 + (to ? TO - 1 : d);
      void'(q.pop_front());
    end
    if (req_valid && sz < DEPTH) begin
      q.push_back({req_function_id, req_inputs_0, req_inputs_1});
      pushes++;
    end
    prev_q = sz;
  endtask
  task automatic step();
    check_cycle();
    drive();
    update();
    @(negedge clk);
    n++;
  endtask
  task automatic push_n(int cnt);
    p_req = 100;
    push_limit = pushes + cnt;
  endtask
  task automatic wait_res(int lim);
    for (int i = 0; i < lim && !res_valid; i++) step();
    chk("res_valid_seen", res_valid, 1);
  endtask
  task automatic drain();
    push_limit = pushes;
    p_cmd = 100;
    p_res = 100;
    for (int i = 0; i < 300 && (busy || txn || q.size() > 0); i++) step();
    chk("drained", busy, 0);
  endtask
  initial begin
    @(negedge clk);
    repeat (3) step();
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_rsp_ready", rsp_ready, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_res_timeout", res_timeout, 0);
    chk("rst_res_data", res_data, 0);
    chk("rst_err", err_sticky, 0);
    chk("rst_busy", busy, 0);
    chk("rst_req_ready", req_ready, 0);
    rst_knob = 0;
    step();
    chk("req_ready_after_reset", req_ready, 1);
    // single request answered two cycles after issue
    fix = 1;
    fix_req = {10'h008, 32'h4000_0000, 32'h4000_0000};
    next_d = 2;
    next_v = 32'h2000_0000;
    p_cmd = 100;
    p_res = 0;
    base = hs_count;
    push_n(1);
    step();
    chk("idle_before_issue", cmd_valid, 0);
    step();
    chk("issue_latency", cmd_valid, 1);
    wait_res(20);
    chk("single_data", res_data, 32'h2000_0000);
    chk("single_timeout", res_timeout, 0);
    chk("single_handshakes", hs_count - base, 1);
    fix = 0;
    drain();
    // five back-to-back pushes against a stalled CFU
    p_cmd = 0;
    base = pushes;
    push_n(5);
    for (int i = 0; i < 20 && pushes < base + 4; i++) step();
    chk("full_after_4", req_ready, 0);
    repeat (3) step();
    chk("fifth_held", pushes - base, 4);
    hb = hs_count;
    p_cmd = 100;
    for (int i = 0; i < 20 && pushes < base + 5; i++) step();
    chk("fifth_after_first_hs", hs_count - hb, 1);
    drain();
    // no response: timeout, then a normal request with err_sticky retained
    next_d = NEVER;
    p_res = 0;
    push_n(1);
    wait_res(40);
    chk("timeout_latency", n - hs_edge, 16);
    chk("timeout_flag", res_timeout, 1);
    chk("timeout_data", res_data, 0);
    chk("timeout_err", err_sticky, 1);
    p_res = 100;
    step();
    p_res = 0;
    next_d = 1;
    push_n(1);
    wait_res(40);
    chk("after_timeout_flag", res_timeout, 0);
    chk("after_timeout_err", err_sticky, 1);
    drain();
    // result held back for ten cycles with a second request queued
    p_res = 0;
    push_n(2);
    wait_res(40);
    hold_v = res_data;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("hold_data", res_data, hold_v);
      chk("hold_cmd_valid", cmd_valid, 0);
      chk("hold_rsp_ready", rsp_ready, 0);
    end
    p_res = 100;
    step();
    chk("next_issue", cmd_valid, 1);
    drain();
    // reset while waiting on a response with three entries queued
    next_d = NEVER;
    p_res = 0;
    push_n(4);
    for (int i = 0; i < 30 && !(rsp_ready && q.size() == 3); i++) step();
    chk("mid_setup", q.size(), 3);
    rst_knob = 1;
    repeat (2) step();
    chk("mid_cmd_valid", cmd_valid, 0);
    chk("mid_rsp_ready", rsp_ready, 0);
    chk("mid_res_valid", res_valid, 0);
    chk("mid_res_data", res_data, 0);
    chk("mid_timeout", res_timeout, 0);
    chk("mid_err", err_sticky, 0);
    chk("mid_busy", busy, 0);
    chk("mid_req_ready", req_ready, 0);
    rst_knob = 0;
    push_limit = pushes;
    p_res = 100;
    seen = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (res_valid) seen++;
    end
    chk("no_result_after_reset", seen, 0);
    // random traffic with random cmd_ready, res_ready and CFU latency
    p_req = 60;
    p_cmd = 50;
    p_res = 60;
    push_limit = pushes + 300;
    repeat (4000) step();
    drain();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
